// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing, widths, sync polarity constants and the colour-bar helper.
package vga_pkg;
  localparam int H_DISPLAY_D = 640;
  localparam int H_FRONT_D = 16;
  localparam int H_SYNC_D = 96;
  localparam int H_BACK_D = 48;
  localparam int V_DISPLAY_D = 480;
  localparam int V_FRONT_D = 10;
  localparam int V_SYNC_D = 2;
  localparam int V_BACK_D = 33;
  localparam int CLK_DIV_D = 2;
  localparam int COLOR_W_D = 3;
  localparam int COUNT_W_D = 10;
  localparam logic SYNC_ACTIVE_LOW = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;
  // Bar index of x for bars w pixels wide: a chain of constant comparators, no divider.
  function automatic logic [2:0] bar_index(input int unsigned x, input int unsigned w);
    logic [2:0] b;
    b = 3'd0;
    for (int k = 1; k < 8; k++)
      if (x >= k * w) b = 3'(k);
    return b;
  endfunction
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis counter (sync, back porch, display, front porch) with region flags.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int SYNC = H_SYNC_D,
  parameter int BACK = H_BACK_D,
  parameter int DISPLAY = H_DISPLAY_D,
  parameter int FRONT = H_FRONT_D,
  parameter int COUNT_W = COUNT_W_D
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_advance,
  output logic [COUNT_W-1:0] o_count,
  output logic               o_in_sync,
  output logic               o_in_display,
  output logic               o_wrap
);
  localparam logic [COUNT_W-1:0] LAST = COUNT_W'(SYNC + BACK + DISPLAY + FRONT - 1);
  localparam logic [COUNT_W-1:0] SYNC_END = COUNT_W'(SYNC);
  localparam logic [COUNT_W-1:0] START = COUNT_W'(SYNC + BACK);
  localparam logic [COUNT_W-1:0] STOP = COUNT_W'(SYNC + BACK + DISPLAY);
  logic [COUNT_W-1:0] r_count;
  logic               r_in_sync;
  logic               r_in_display;
  logic [COUNT_W-1:0] w_next;
  assign w_next = r_count == LAST ? '0 : r_count + 1'b1;
  assign o_wrap = i_advance && r_count == LAST;
  assign o_count = r_count;
  assign o_in_sync = r_in_sync;
  assign o_in_display = r_in_display;
  // Flags are registered with the count so they always describe the value just loaded.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_count <= '0;
      r_in_sync <= SYNC > 0;
      r_in_display <= 1'b0;
    end else if (i_advance) begin
      r_count <= w_next;
      r_in_sync <= w_next < SYNC_END;
      r_in_display <= w_next >= START && w_next < STOP;
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with a one-pixel colour/sync pipeline.
// Define VGA_TEST_PATTERN_EN to add the testPattern input and an eight-bar colour generator.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_DISPLAY = H_DISPLAY_D,
  parameter int H_FRONT = H_FRONT_D,
  parameter int H_SYNC = H_SYNC_D,
  parameter int H_BACK = H_BACK_D,
  parameter int V_DISPLAY = V_DISPLAY_D,
  parameter int V_FRONT = V_FRONT_D,
  parameter int V_SYNC = V_SYNC_D,
  parameter int V_BACK = V_BACK_D,
  parameter int CLK_DIV = CLK_DIV_D,
  parameter logic H_SYNC_POL = SYNC_ACTIVE_LOW,
  parameter logic V_SYNC_POL = SYNC_ACTIVE_LOW,
  parameter int COLOR_W = COLOR_W_D,
  parameter int COUNT_W = COUNT_W_D
) (
  input  logic               clk,
  input  logic               rst,
`ifdef VGA_TEST_PATTERN_EN
  input  logic               testPattern,
`endif
  input  logic [COLOR_W-1:0] pixelColor,
  output logic [COUNT_W-1:0] pixelX,
  output logic [COUNT_W-1:0] pixelY,
  output logic               display,
  output logic               pixelStrobe,
  output logic               frameStart,
  output logic [COLOR_W-1:0] color,
  output logic               hSync,
  output logic               vSync
);
  localparam int DIV_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [COUNT_W-1:0] H_START = COUNT_W'(H_SYNC + H_BACK);
  localparam logic [COUNT_W-1:0] V_START = COUNT_W'(V_SYNC + V_BACK);
  logic [DIV_W-1:0]   r_div;
  logic               r_strobe;
  logic               r_frame;
  logic [COLOR_W-1:0] r_color;
  logic               r_hs;
  logic               r_vs;
  logic               w_tick;
  logic [COUNT_W-1:0] w_hcount;
  logic [COUNT_W-1:0] w_vcount;
  logic               w_h_sync;
  logic               w_v_sync;
  logic               w_h_disp;
  logic               w_v_disp;
  logic               w_h_wrap;
  logic               w_v_wrap;
  logic [COLOR_W-1:0] w_color;
  assign w_tick = r_div == DIV_LAST;
  vga_axis_counter #(
    .SYNC(H_SYNC), .BACK(H_BACK), .DISPLAY(H_DISPLAY), .FRONT(H_FRONT), .COUNT_W(COUNT_W)
  ) u_h (
    .clk(clk), .rst(rst), .i_advance(w_tick), .o_count(w_hcount),
    .o_in_sync(w_h_sync), .o_in_display(w_h_disp), .o_wrap(w_h_wrap)
  );
  vga_axis_counter #(
    .SYNC(V_SYNC), .BACK(V_BACK), .DISPLAY(V_DISPLAY), .FRONT(V_FRONT), .COUNT_W(COUNT_W)
  ) u_v (
    .clk(clk), .rst(rst), .i_advance(w_h_wrap), .o_count(w_vcount),
    .o_in_sync(w_v_sync), .o_in_display(w_v_disp), .o_wrap(w_v_wrap)
  );
  assign display = w_h_disp && w_v_disp;
  assign pixelX = display ? w_hcount - H_START : '0;
  assign pixelY = display ? w_vcount - V_START : '0;
`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] w_bar;
  assign w_bar = bar_index(32'(pixelX), H_DISPLAY / 8);
  assign w_color = !display ? '0 : testPattern ? COLOR_W'(w_bar) : pixelColor;
`else
  assign w_color = display ? pixelColor : '0;
`endif
  assign pixelStrobe = r_strobe;
  assign frameStart = r_frame;
  assign color = r_color;
  assign hSync = r_hs;
  assign vSync = r_vs;
  // Stage 1 samples the stage-0 flags before they advance, delaying sync to line up with colour.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_div <= '0;
      r_strobe <= 1'b0;
      r_frame <= 1'b0;
      r_color <= '0;
      r_hs <= ~H_SYNC_POL;
      r_vs <= ~V_SYNC_POL;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      r_strobe <= w_tick;
      r_frame <= w_v_wrap;
      if (w_tick) begin
        r_color <= w_color;
        r_hs <= w_h_sync ? H_SYNC_POL : ~H_SYNC_POL;
        r_vs <= w_v_sync ? V_SYNC_POL : ~V_SYNC_POL;
      end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks on a default, a tiny and a medium vga_timing_gen instance.
module tb_vga_timing_gen;
  logic clk;
  logic rst;
  logic [2:0] a_pc, b_pc, c_pc;
  logic [9:0] a_x, a_y, b_x, b_y, c_x, c_y;
  logic a_disp, a_stb, a_fs, a_hs, a_vs;
  logic b_disp, b_stb, b_fs, b_hs, b_vs;
  logic c_disp, c_stb, c_fs, c_hs, c_vs;
  logic [2:0] a_col, b_col, c_col;
  logic tp, tp_off;
  int total, bad;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  vga_timing_gen u_a (
    .clk(clk), .rst(rst),
`ifdef VGA_TEST_PATTERN_EN
    .testPattern(tp_off),
`endif
    .pixelColor(a_pc), .pixelX(a_x), .pixelY(a_y), .display(a_disp), .pixelStrobe(a_stb),
    .frameStart(a_fs), .color(a_col), .hSync(a_hs), .vSync(a_vs)
  );
  vga_timing_gen #(
    .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_DISPLAY(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .CLK_DIV(1), .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
  ) u_b (
    .clk(clk), .rst(rst),
`ifdef VGA_TEST_PATTERN_EN
    .testPattern(tp_off),
`endif
    .pixelColor(b_pc), .pixelX(b_x), .pixelY(b_y), .display(b_disp), .pixelStrobe(b_stb),
    .frameStart(b_fs), .color(b_col), .hSync(b_hs), .vSync(b_vs)
  );
  vga_timing_gen #(
    .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .CLK_DIV(2)
  ) u_c (
    .clk(clk), .rst(rst),
`ifdef VGA_TEST_PATTERN_EN
    .testPattern(tp),
`endif
    .pixelColor(c_pc), .pixelX(c_x), .pixelY(c_y), .display(c_disp), .pixelStrobe(c_stb),
    .frameStart(c_fs), .color(c_col), .hSync(c_hs), .vSync(c_vs)
  );
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  initial begin
    int a_falls[2];
    int c_fsn[2];
    int a_nf, a_low, c_vlow, c_first, c_nfs, prev_x, exp_col, waited;
    logic a_prev_hs, prev_disp;
    total = 0; bad = 0;
    a_nf = 0; a_low = 0; c_vlow = 0; c_first = 0; c_nfs = 0;
    a_falls = '{0, 0}; c_fsn = '{0, 0};
    prev_x = 0; prev_disp = 1'b0; a_prev_hs = 1'b1;
    a_pc = 3'd0; b_pc = 3'd0; c_pc = 3'd0; tp = 1'b1; tp_off = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_a_hsync", a_hs, 1);
    chk("rst_a_vsync", a_vs, 1);
    chk("rst_a_strobe", a_stb, 0);
    chk("rst_a_display", a_disp, 0);
    chk("rst_b_hsync", b_hs, 0);
    chk("rst_b_vsync", b_vs, 0);
    chk("rst_c_color", c_col, 0);
    chk("rst_c_frame", c_fs, 0);
    rst = 1'b1;
    for (int n = 1; n <= 3400; n++) begin
      @(negedge clk);
      if (n <= 20) chk("a_strobe", a_stb, n % 2 == 0);
      if (n <= 1601 && !a_hs) a_low++;
      if (a_prev_hs && !a_hs && a_nf < 2) begin
        a_falls[a_nf] = n;
        a_nf++;
      end
      a_prev_hs = a_hs;
      if (n <= 70) begin
        chk("b_hsync", b_hs, (n - 1) % 7 == 0);
        chk("b_vsync", b_vs, ((n - 1) / 7) % 5 == 0);
      end
      if (n <= 210) chk("b_frame", b_fs, n % 35 == 0);
      if (n <= 368 && !c_vs) c_vlow++;
      if (c_disp && c_first == 0) begin
        c_first = n;
        chk("c_first_x", c_x, 0);
        chk("c_first_y", c_y, 0);
      end
      if (n == 316) begin
        chk("c_last_x", c_x, 15);
        chk("c_last_y", c_y, 3);
        chk("c_last_disp", c_disp, 1);
      end
      if (n == 318) chk("c_after_last_disp", c_disp, 0);
      if (c_fs && c_nfs < 2) begin
        c_fsn[c_nfs] = n;
        c_nfs++;
      end
      if (c_stb && n <= 800) begin
`ifdef VGA_TEST_PATTERN_EN
        exp_col = prev_disp ? prev_x / 2 : 0;
`else
        exp_col = prev_disp ? prev_x % 8 : 0;
`endif
        chk("c_color", c_col, exp_col);
        prev_disp = c_disp;
        prev_x = int'(c_x);
        c_pc = c_x[2:0];
      end
    end
    chk("a_hsync_first_fall", a_falls[0], 2);
    chk("a_line_period", a_falls[1], 1602);
    chk("a_hsync_low_clks", a_low, 192);
    chk("c_vsync_low_clks", c_vlow, 92);
    chk("c_first_display_clk", c_first, 148);
    chk("c_frame_first", c_fsn[0], 368);
    chk("c_frame_second", c_fsn[1], 736);
    waited = 0;
    while (!c_disp && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    chk("c_wait_display", c_disp, 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_c_display", c_disp, 0);
    chk("mid_c_x", c_x, 0);
    chk("mid_c_y", c_y, 0);
    chk("mid_c_color", c_col, 0);
    chk("mid_c_strobe", c_stb, 0);
    chk("mid_c_vsync", c_vs, 1);
    chk("mid_a_hsync", a_hs, 1);
    chk("mid_b_hsync", b_hs, 0);
    chk("mid_b_vsync", b_vs, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      chk("re_b_frame", b_fs, n == 35);
      if (n <= 7) chk("re_b_hsync", b_hs, n == 1);
      if (n <= 4) begin
        chk("re_c_strobe", c_stb, n % 2 == 0);
        chk("re_c_display", c_disp, 0);
      end
      if (n == 2) chk("re_c_hsync", c_hs, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator. It succeeds the fixed 640x480 controller with configurable porch and sync widths, sync polarity, pixel-clock divide ratio and colour width. It publishes pixel coordinates and a strobe so an upstream frame-buffer or sprite engine can supply colour. It sits between the pixel source and the VGA connector pins.

## Interface
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hSync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vSync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 2, clk cycles per pixel (>=1)
- H_SYNC_POL, 0, active level of hSync
- V_SYNC_POL, 0, active level of vSync
- COLOR_W, 3, colour bits
- COUNT_W, 10, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- pixelColor  in  COLOR_W  colour for the coordinate presented on the previous strobe
- pixelX  out  COUNT_W  display-relative column; 0 outside the display window
- pixelY  out  COUNT_W  display-relative row; 0 outside the display window
- display  out  1  current coordinate is visible
- pixelStrobe  out  1  one-clk pulse; the counters and coordinates just advanced
- frameStart  out  1  one-clk pulse when counters wrap to (0,0)
- color  out  COLOR_W  pixel colour to the DAC
- hSync, vSync  out  1  sync outputs, polarity per parameter

## Operation
- H_TOTAL = H_SYNC+H_BACK+H_DISPLAY+H_FRONT. V_TOTAL is formed the same way.
- Region order on both axes: sync, back porch, display, front porch, starting at count 0.
- Divider divCount runs 0..CLK_DIV-1. tick = (divCount == CLK_DIV-1). With CLK_DIV=1, tick is high every cycle.
- On tick:
  - hCount increments.
  - At H_TOTAL-1, hCount wraps to 0 and vCount increments.
  - At V_TOTAL-1 with hCount wrapping, vCount wraps to 0.
- Stage 0 is registered on tick:
  - display = hCount in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISPLAY) and vCount in the vertical equivalent.
  - pixelX = hCount-(H_SYNC+H_BACK) when display, else 0. pixelY is formed the same way.
  - pixelStrobe is high for the one clk after each tick edge.
  - frameStart is high for the clk after the edge on which the counters became (0,0).
- Stage 1 is registered on the next tick:
  - color = stage-0 display ? pixelColor : 0.
  - hSync and vSync are the stage-0 sync-region flags, delayed one tick and driven at the polarity parameter. This aligns them with color.
- The pixel source has one full pixel period after pixelStrobe to drive pixelColor.
- Reset values (asynchronous, immediate):
  - divCount, hCount and vCount are 0.
  - pixelX, pixelY, display, pixelStrobe, frameStart and color are 0.
  - hSync = ~H_SYNC_POL and vSync = ~V_SYNC_POL (inactive).
- Reset asserted mid-line or mid-frame aborts the frame. After release, the first tick occurs after CLK_DIV clk edges, and timing restarts at (0,0) in the sync region.
- Arithmetic is unsigned COUNT_W. Parameters are static; the block performs no runtime checks. Bench assertions check that every width is >=1 and CLK_DIV>=1.

## Timing
- Latency: coordinate to color/sync output is exactly 1 pixel (CLK_DIV clks).
- Line period: H_TOTAL*CLK_DIV clks. Frame period: H_TOTAL*V_TOTAL*CLK_DIV clks.
- hSync is active for H_SYNC ticks on every line, including vertical blanking lines.
- vSync is active for V_SYNC whole lines.
- Last pixel of a line and last line of a frame coincide on one tick: both wraps happen on the same edge, and frameStart pulses once.

## Configuration
- VGA_TEST_PATTERN_EN defined:
  - Adds input port testPattern (1 bit).
  - When it is high, stage-1 color = bar index of pixelX, where bar = pixelX/(H_DISPLAY/8), truncated to COLOR_W. The division is implemented as a comparator chain against constants.
  - pixelColor is ignored while testPattern is high.
  - Blanking still forces 0.
- Undefined: the port is absent and color always comes from pixelColor.

## Structure
- Package vga_pkg holds:
  - Default 640x480@60 timing constants.
  - Default COLOR_W and COUNT_W.
  - Sync polarity constants SYNC_ACTIVE_LOW/SYNC_ACTIVE_HIGH.
- Sub-module vga_axis_counter is instantiated twice (horizontal and vertical).
  - Parameters: SYNC, BACK, DISPLAY, FRONT.
  - Inputs: advance enable.
  - Outputs: count, inSync, inDisplay, wrap.

## Test plan
- Reset then release with defaults:
  - pixelStrobe every 2 clks.
  - hSync low for 192 clks at line start.
  - Line period 1600 clks.
- Frame with defaults:
  - vSync low for exactly 2 lines (3200 clks).
  - frameStart period 840000 clks.
- Display window:
  - First display=1 at hCount=144, vCount=35 with pixelX=0, pixelY=0.
  - Last visible coordinate is pixelX=639, pixelY=479; display=0 on the next tick.
- Pipeline: drive pixelColor = pixelX[2:0] each strobe.
  - color lags one pixel and matches.
  - color = 0 throughout blanking.
- Small config (4/1/1/1, 2/1/1/1, CLK_DIV=1, both polarities 1):
  - 7-clk lines, 5-line frame.
  - Active-high syncs.
  - Simultaneous h/v wrap yields a single frameStart.
- Reset pulsed mid-line: outputs reach reset values within the reset cycle, and timing restarts at (0,0). With VGA_TEST_PATTERN_EN and testPattern=1, colour bars 0..7 change every 80 pixels.
